// File: rtl/seq_alu.sv
// seq_alu: single-issue ALU with a valid/ready request port and a held result port.
// Logic, add, subtract and set-less-than results are registered at the accept edge.
// Unsigned multiply runs as a shift-add loop over WIDTH cycles.
//
//   state | meaning
//   IDLE  | in_ready=1, waiting for a request
//   MUL   | shift-add multiply in progress, one multiplier bit per cycle
//   DONE  | out_valid=1, result held until out_ready
module seq_alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       f,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             cout,
  output logic             overflow,
  output logic             zero
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

  state_t             r_state;
  logic               r_in_ready;
  logic               r_out_valid;
  logic [WIDTH-1:0]   r_y;
  logic               r_cout;
  logic               r_ov;
  logic               r_zero;
  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [CW-1:0]      r_count;

  logic [WIDTH-1:0]   w_bb;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH-1:0]   w_s;
  logic               w_sov;
  logic [WIDTH-1:0]   w_res;
  logic               w_res_c;
  logic               w_res_ov;
  logic [2*WIDTH-1:0] w_acc_next;
  logic               w_last;

  // Single-cycle datapath: shared adder for add/sub/SLT plus the logic ops.
  always_comb begin
    w_bb     = f[2] ? ~b : b;
    w_sum    = {1'b0, a} + {1'b0, w_bb} + {{WIDTH{1'b0}}, f[2]};
    w_s      = w_sum[WIDTH-1:0];
    // Signed overflow: both adder inputs share a sign that the sum does not.
    w_sov    = (a[WIDTH-1] == w_bb[WIDTH-1]) && (w_s[WIDTH-1] != a[WIDTH-1]);
    w_res    = '0;
    w_res_c  = 1'b0;
    w_res_ov = 1'b0;
    case (f)
      3'b000: w_res = a & b;
      3'b001: w_res = a | b;
      3'b100: w_res = a & ~b;
      3'b101: w_res = a | ~b;
      3'b010, 3'b110: begin
        w_res    = w_s;
        w_res_c  = w_sum[WIDTH];
        w_res_ov = w_sov;
      end
      3'b111: w_res = {{(WIDTH-1){1'b0}}, w_s[WIDTH-1] ^ w_sov};
      default: w_res = '0;
    endcase
  end

  // Next accumulator value for the current multiplier bit.
  always_comb begin
    w_acc_next = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
    w_last     = (r_count == LAST_ITER);
  end

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_y         <= '0;
      r_cout      <= 1'b0;
      r_ov        <= 1'b0;
      r_zero      <= 1'b1;
      r_acc       <= '0;
      r_mcand     <= '0;
      r_mplier    <= '0;
      r_count     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_in_ready <= 1'b0;
            if (f == 3'b011) begin
              r_acc    <= '0;
              r_mcand  <= {{WIDTH{1'b0}}, a};
              r_mplier <= b;
              r_count  <= '0;
              r_state  <= MUL;
            end else begin
              r_y         <= w_res;
              r_cout      <= w_res_c;
              r_ov        <= w_res_ov;
              r_zero      <= (w_res == '0);
              r_out_valid <= 1'b1;
              r_state     <= DONE;
            end
          end
        end
        MUL: begin
          r_acc    <= w_acc_next;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_count  <= r_count + CW'(1);
          if (w_last) begin
            r_y         <= w_acc_next[WIDTH-1:0];
            r_cout      <= 1'b0;
            r_ov        <= |w_acc_next[2*WIDTH-1:WIDTH];
            r_zero      <= (w_acc_next[WIDTH-1:0] == '0);
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end
        end
        DONE: begin
          // Returning to IDLE here means a new request is taken no earlier than the next edge.
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign y         = r_y;
  assign cout      = r_cout;
  assign overflow  = r_ov;
  assign zero      = r_zero;

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: scoreboard bench for seq_alu with directed corner cases and random traffic.
module tb_seq_alu;
  localparam int W = 32;
  localparam longint SMAX = (64'sd1 <<< (W - 1)) - 64'sd1;
  localparam longint SMIN = -(64'sd1 <<< (W - 1));

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [2:0]   f = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] y;
  logic         cout;
  logic         overflow;
  logic         zero;

  seq_alu #(.WIDTH(W)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .f(f), .out_valid(out_valid), .out_ready(out_ready),
    .y(y), .cout(cout), .overflow(overflow), .zero(zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] y;
    logic         c;
    logic         ov;
    logic         z;
    bit           is_mul;
    int           acc_cyc;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_err = 0;
  int   cycle = 0;
  int   rdy_mode = 1;  // 0 random, 1 always ready, 2 stalled

  always @(posedge clk) cycle <= cycle + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model from the operation definitions using wide signed/unsigned arithmetic.
  function automatic exp_t model(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic [2:0] iop);
    exp_t e;
    longint sa, sb_, r;
    longint unsigned ua, ub, p;
    sa = $signed(ia);
    sb_ = $signed(ib);
    ua = {32'd0, ia};
    ub = {32'd0, ib};
    e.y = '0; e.c = 1'b0; e.ov = 1'b0; e.is_mul = 1'b0; e.acc_cyc = 0;
    case (iop)
      3'b000: e.y = ia & ib;
      3'b001: e.y = ia | ib;
      3'b100: e.y = ia & ~ib;
      3'b101: e.y = ia | ~ib;
      3'b010: begin
        p = ua + ub; r = sa + sb_;
        e.y = p[W-1:0]; e.c = p[W]; e.ov = (r > SMAX) || (r < SMIN);
      end
      3'b110: begin
        p = ua - ub; r = sa - sb_;
        e.y = p[W-1:0]; e.c = (ua >= ub); e.ov = (r > SMAX) || (r < SMIN);
      end
      3'b111: e.y = (sa < sb_) ? W'(1) : W'(0);
      default: begin
        p = ua * ub;
        e.y = p[W-1:0]; e.ov = ((p >> W) != 0); e.is_mul = 1'b1;
      end
    endcase
    e.z = (e.y == '0);
    return e;
  endfunction

  // Monitor: pops one expectation per presented result and re-checks it every held cycle.
  exp_t cur;
  bit   held = 1'b0;
  always @(negedge clk) begin
    if (!reset_n) begin
      held = 1'b0;
      sb.delete();
    end else if (out_valid) begin
      if (!held) begin
        if (sb.size() == 0) begin
          n_chk++; n_err++;
          $display("FAIL unexpected_result: got y=%0h expected no output (t=%0t)", y, $time);
        end else begin
          cur = sb.pop_front();
          held = 1'b1;
          chk("latency", 64'(cycle - cur.acc_cyc), cur.is_mul ? 64'(W) : 64'd0);
        end
      end
      if (held) begin
        chk("y", 64'(y), 64'(cur.y));
        chk("cout", 64'(cout), 64'(cur.c));
        chk("overflow", 64'(overflow), 64'(cur.ov));
        chk("zero", 64'(zero), 64'(cur.z));
        chk("in_ready_busy", 64'(in_ready), 64'd0);
      end
      if (out_ready) held = 1'b0;
    end
  end

  // Consumer-side ready pattern, updated mid-cycle.
  initial forever begin
    @(posedge clk);
    #2;
    case (rdy_mode)
      0: out_ready = ($urandom_range(0, 3) != 0);
      1: out_ready = 1'b1;
      default: out_ready = 1'b0;
    endcase
  end

  // Drive one cycle of inputs (called at posedge+1); records an accept when IDLE sees in_valid.
  task automatic drive_cycle(input bit v, input logic [W-1:0] ia, input logic [W-1:0] ib,
                             input logic [2:0] iop, output bit accepted);
    exp_t e;
    in_valid = v; a = ia; b = ib; f = iop;
    accepted = 1'b0;
    @(negedge clk);
    if (in_valid && in_ready && reset_n) begin
      e = model(a, b, f);
      e.acc_cyc = cycle + 1;
      sb.push_back(e);
      accepted = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic [2:0] iop);
    bit acc;
    int tries;
    acc = 1'b0;
    tries = 0;
    while (!acc && tries < 200) begin
      drive_cycle(1'b1, ia, ib, iop, acc);
      tries++;
    end
    in_valid = 1'b0;
    if (!acc) begin
      n_chk++; n_err++;
      $display("FAIL send_timeout: got no accept expected accept within 200 cycles");
    end
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    in_valid = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && in_ready && !out_valid) done = 1'b1;
      @(posedge clk);
      #1;
    end
    if (!done) begin
      n_chk++; n_err++;
      $display("FAIL drain_timeout: got pending=%0d expected idle within 400 cycles", sb.size());
    end
  endtask

  function automatic logic [W-1:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return '0;
      1: return '1;
      2: return {1'b0, {(W-1){1'b1}}};
      3: return {1'b1, {(W-1){1'b0}}};
      4: return W'($urandom_range(0, 15));
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish before 500000ns");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    // Reset values while held in reset.
    #12;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_y", 64'(y), 64'd0);
    chk("rst_cout", 64'(cout), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    chk("rst_zero", 64'(zero), 64'd1);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;

    // Directed corner cases with the consumer always ready.
    rdy_mode = 1;
    send(32'h7FFFFFFF, 32'h1, 3'b010);
    send(32'h5, 32'h5, 3'b110);
    send(32'hFFFFFFFF, 32'h1, 3'b111);
    send(32'h7FFFFFFF, 32'h80000000, 3'b111);
    send(32'h10000, 32'h10000, 3'b011);
    send(32'h7, 32'h6, 3'b011);
    send(32'hFFFFFFFF, 32'hFFFFFFFF, 3'b011);
    send(32'h80000000, 32'h1, 3'b110);
    send(32'hF0F0F0F0, 32'hFF00FF00, 3'b000);
    send(32'hF0F0F0F0, 32'hFF00FF00, 3'b001);
    send(32'hF0F0F0F0, 32'hFF00FF00, 3'b100);
    send(32'hF0F0F0F0, 32'hFF00FF00, 3'b101);
    drain();

    // Backpressure: stalled consumer, busy requests must be ignored.
    rdy_mode = 2;
    send(32'h1234, 32'h5678, 3'b010);
    repeat (10) begin
      drive_cycle(1'b1, W'($urandom), W'($urandom), 3'($urandom_range(0, 7)), acc);
      chk("bp_no_accept", 64'(acc), 64'd0);
    end
    in_valid = 1'b0;
    rdy_mode = 1;
    drain();

    // Reset in the middle of a multiply.
    send(32'h3, 32'h3, 3'b011);
    repeat (4) @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    chk("midmul_rst_out_valid", 64'(out_valid), 64'd0);
    chk("midmul_rst_y", 64'(y), 64'd0);
    chk("midmul_rst_zero", 64'(zero), 64'd1);
    #10;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(negedge clk);
    chk("midmul_rel_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    send(32'h2, 32'h3, 3'b010);
    drain();

    // Random traffic with random consumer stalls.
    rdy_mode = 0;
    for (int i = 0; i < 1500; i++) begin
      drive_cycle(bit'($urandom_range(0, 1)), pick_operand(), pick_operand(),
                  3'($urandom_range(0, 7)), acc);
    end
    rdy_mode = 1;
    drain();
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule
